// File: rtl/reg_file.sv
// 32x32 integer register file: two combinational read ports, one clocked write port.
// Register 0 is never written and always reads as zero.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // No write bypass: a same-cycle read of the target returns the old value.
  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expected read data is queued from a shadow model
// when addresses are driven, then popped and compared once the reads settle.
module tb_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] raddr1 = '0;
  logic [AW-1:0] raddr2 = '0;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;

  logic [DW-1:0] model [N];
  logic [DW-1:0] exp_q [$];
  int total = 0;
  int bad = 0;

  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_clr();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [DW-1:0] e1, e2;
    raddr1 = a1;
    raddr2 = a2;
    exp_q.push_back((a1 == '0) ? '0 : model[a1]);
    exp_q.push_back((a2 == '0) ? '0 : model[a2]);
    #1;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    chk($sformatf("%s/p1[%0d]", tag, a1), rdata1, e1);
    chk($sformatf("%s/p2[%0d]", tag, a2), rdata2, e2);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    if (rst_n && a != '0) model[a] = d;
    #1;
    we = 1'b0;
  endtask

  initial begin
    model_clr();
    repeat (2) @(negedge clk);
    for (int a = 0; a < N; a++) rd("in_rst", AW'(a), AW'(N - 1 - a));
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < N; a++) rd("post_rst", AW'(a), AW'(a));

    wr(5'd1, 32'h1234_5678);
    rd("r1", 5'd1, 5'd0);
    rd("dual", 5'd1, 5'd1);

    wr(5'd2, 32'h8765_4321);
    rd("nocross", 5'd2, 5'd1);

    @(negedge clk);
    we = 1'b1; waddr = '0; wdata = 32'hDEAD_BEEF;
    rd("z_pre", 5'd0, 5'd3);
    @(posedge clk);
    #1;
    we = 1'b0;
    rd("z_post", 5'd0, 5'd3);

    @(negedge clk);
    we = 1'b0; waddr = 5'd1; wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    rd("we0", 5'd1, 5'd2);

    @(negedge clk);
    we = 1'b1; waddr = 5'd4; wdata = 32'hA5A5_A5A5;
    rd("rdw_pre", 5'd4, 5'd4);
    @(posedge clk);
    model[4] = 32'hA5A5_A5A5;
    #1;
    we = 1'b0;
    rd("rdw_post", 5'd4, 5'd4);

    for (int i = 0; i < 40; i++) begin
      wr(AW'($urandom_range(0, N - 1)), $urandom);
      rd("rand", AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)));
    end

    // Asynchronous reset mid-cycle, then a write attempt held through reset.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_clr();
    rd("arst", 5'd1, 5'd4);
    wr(5'd5, 32'h5555_AAAA);
    for (int a = 0; a < N; a++) rd("arst_all", AW'(a), AW'(N - 1 - a));
    @(negedge clk);
    rst_n = 1'b1;
    wr(5'd5, 32'hCAFE_F00D);
    rd("first_wr", 5'd5, 5'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose integer register file for the CPU datapath.
- 32 entries of 32 bits, two asynchronous read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
- DATA_W, 32, width of each register and of the data ports
- ADDR_W, 5, width of the address ports; the file holds 2**ADDR_W entries

Ports:
- clk  input  1  system clock; writes occur on the rising edge
- rst_n  input  1  asynchronous active-low reset; clears all registers
- we  input  1  write enable, sampled on the rising clk edge
- waddr  input  ADDR_W  write register index
- wdata  input  DATA_W  write data
- raddr1  input  ADDR_W  read port 1 register index
- rdata1  output  DATA_W  read port 1 data (combinational)
- raddr2  input  ADDR_W  read port 2 register index
- rdata2  output  DATA_W  read port 2 data (combinational)

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits.
- Reset:
  - rst_n low clears every register to 0 immediately, independent of clk.
  - While rst_n is low, writes are ignored and both read ports return 0.
  - Deassertion takes effect with no extra latency; the first write is accepted on the first rising edge with rst_n high.
- Write:
  - On the rising edge of clk with rst_n high, we=1 and waddr!=0, the register at waddr takes wdata.
  - we=0 leaves all registers unchanged; wdata and waddr are don't-care.
- Register 0:
  - Writes with waddr=0 are discarded.
  - Register 0 always reads 0, including directly after an attempted write.
- Read:
  - Purely combinational. rdata1 = reg[raddr1] and rdata2 = reg[raddr2], with a forced 0 when the address is 0.
  - Outputs settle within the same cycle when the address changes; no clock latency.
- Dual read: both ports may address the same register at the same time and both return the same value.
- Read-during-write, same cycle:
  - No write-to-read bypass.
  - Before the edge, a read of the register being written returns the old value.
  - After the edge, the read returns the new wdata.
- Never-written registers read 0 after reset; no X is ever driven after reset.
- Write and reset together: reset wins and the register stays 0.
- All widths are exact; no sign or zero extension is performed.

Test Plan:
- Reset pulse, then read all 32 addresses on both ports -> every read returns 0x00000000.
- Write 0x12345678 to reg 1 (we=1, one edge), drop we, raddr1=1 -> rdata1=0x12345678. Then raddr2=1 -> rdata2=0x12345678 on both ports at once.
- Write 0x87654321 to reg 2; raddr1=2, raddr2=1 -> rdata1=0x87654321 and rdata2=0x12345678 (no cross-corruption).
- Write 0xDEADBEEF with waddr=0, we=1; raddr1=0 -> rdata1=0x00000000 both before and after the edge. Reading reg 3 (never written) also returns 0x00000000.
- we=0 with waddr=1 and wdata=0xFFFFFFFF over several edges -> reg 1 still reads 0x12345678.
- Same-cycle check: raddr1=4 while writing 0xA5A5A5A5 to reg 4 -> rdata1=0 before the edge and 0xA5A5A5A5 after it.
- Assert rst_n low mid-cycle after writes -> all reads return 0 immediately, without a clock edge.
